// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetch_stage_if #(
    parameter int W = 32
);
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] addr;
    logic         rsp_valid;
    logic [W-1:0] rdata;

    modport master (
        output req_valid,
        output addr,
        input  req_ready,
        input  rsp_valid,
        input  rdata
    );

    modport slave (
        input  req_valid,
        input  addr,
        output req_ready,
        output rsp_valid,
        output rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
//
// state | meaning
// ------+------------------------------------------------------------
// FETCH | no request in flight; issue one for pcF when allowed
// WAIT  | one request in flight; its response is wanted
// DROP  | one request in flight whose response must be discarded
//       | (a redirect happened while it was outstanding)
module fetch_stage #(
    parameter int           W        = 32,
    parameter logic [W-1:0] RESET_PC = '0,
    parameter logic [W-1:0] NOP      = W'(32'h0000_0013)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stallD,
    input  logic                 flushD,
    input  logic                 pcsrcE,
    input  logic [W-1:0]         pctargetE,
    fetch_stage_if.master        imem,
    output logic [W-1:0]         instrD,
    output logic [W-1:0]         pcD,
    output logic [W-1:0]         pcplus4D,
    output logic                 validD
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } st_t;

    st_t          st;
    st_t          st_nxt;
    logic [W-1:0] pcF;
    logic [W-1:0] pc_pend;
    logic [W-1:0] buf_instr;
    logic [W-1:0] buf_pc;
    logic         buf_v;

    logic         accept;
    logic         rsp_live;
    logic         rsp_to_ifid;
    logic         rsp_to_buf;
    logic         buf_drain;

    assign accept = imem.req_valid & imem.req_ready;

    // A response is only worth keeping in WAIT and when no redirect kills it.
    // While the buffer is occupied it is being drained into IF/ID, so a
    // response arriving then has to take the buffer slot instead.
    assign rsp_live    = (st == WAIT) & imem.rsp_valid & ~pcsrcE;
    assign rsp_to_ifid = rsp_live & ~stallD & ~flushD & ~buf_v;
    assign rsp_to_buf  = rsp_live & ~rsp_to_ifid;
    assign buf_drain   = buf_v & ~pcsrcE & ~flushD & ~stallD;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) st <= FETCH;
        else     st <= st_nxt;
    end

    // Next-state logic.
    always_comb begin
        st_nxt = st;
        unique case (st)
            FETCH: begin
                if (accept) st_nxt = WAIT;
            end
            WAIT: begin
                if (imem.rsp_valid) begin
                    if (pcsrcE)      st_nxt = FETCH;
                    else if (accept) st_nxt = WAIT;
                    else             st_nxt = FETCH;
                end else if (pcsrcE) begin
                    st_nxt = DROP;
                end
            end
            DROP: begin
                if (imem.rsp_valid) st_nxt = FETCH;
            end
            default: st_nxt = FETCH;
        endcase
    end

    // Request outputs; combinational from rsp_valid so fetch can run back-to-back.
    always_comb begin
        imem.req_valid = ~rst & ~pcsrcE & ~buf_v &
                         ((st == FETCH) | ((st == WAIT) & imem.rsp_valid & ~stallD));
        imem.addr      = pcF;
    end

    // Fetch PC and PC of the outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcF     <= RESET_PC;
            pc_pend <= '0;
        end else begin
            if (pcsrcE)      pcF <= pctargetE;
            else if (accept) pcF <= pcF + W'(4);
            if (accept) pc_pend <= pcF;
        end
    end

    // One-entry skid buffer for responses that cannot enter IF/ID yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v     <= 1'b0;
            buf_instr <= NOP;
            buf_pc    <= '0;
        end else if (pcsrcE) begin
            buf_v <= 1'b0;
        end else if (rsp_to_buf) begin
            buf_instr <= imem.rdata;
            buf_pc    <= pc_pend;
            buf_v     <= 1'b1;
        end else if (buf_drain) begin
            buf_v <= 1'b0;
        end
    end

    // IF/ID pipeline register; flush/redirect beats stall, buffer beats memory.
    always_ff @(posedge clk) begin
        if (rst || pcsrcE || flushD) begin
            instrD   <= NOP;
            pcD      <= '0;
            pcplus4D <= '0;
            validD   <= 1'b0;
        end else if (stallD) begin
            instrD   <= instrD;
            pcD      <= pcD;
            pcplus4D <= pcplus4D;
            validD   <= validD;
        end else if (buf_v) begin
            instrD   <= buf_instr;
            pcD      <= buf_pc;
            pcplus4D <= buf_pc + W'(4);
            validD   <= 1'b1;
        end else if (rsp_to_ifid) begin
            instrD   <= imem.rdata;
            pcD      <= pc_pend;
            pcplus4D <= pc_pend + W'(4);
            validD   <= 1'b1;
        end else begin
            instrD   <= NOP;
            pcD      <= '0;
            pcplus4D <= '0;
            validD   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a one-outstanding instruction memory model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallD;
    logic        flushD;
    logic        pcsrcE;
    logic [31:0] pctargetE;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pcplus4D;
    logic        validD;

    int          n_chk  = 0;
    int          n_pass = 0;

    fetch_stage_if #(.W(32)) bus ();

    fetch_stage #(.W(32), .RESET_PC(32'h0), .NOP(NOP)) dut (
        .clk      (clk),
        .rst      (rst),
        .stallD   (stallD),
        .flushD   (flushD),
        .pcsrcE   (pcsrcE),
        .pctargetE(pctargetE),
        .imem     (bus.master),
        .instrD   (instrD),
        .pcD      (pcD),
        .pcplus4D (pcplus4D),
        .validD   (validD)
    );

    always #5 clk = ~clk;

    // Memory model: rdata = addr ^ KEY, response mem_delay cycles after the
    // first possible slot; drops anything outstanding on reset.
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt  = 0;
    int          mem_delay;

    assign bus.req_ready = 1'b1;
    assign bus.rsp_valid = mem_pend && (mem_cnt == 0);
    assign bus.rdata     = mem_addr ^ KEY;

    // Track the single outstanding request.
    always @(posedge clk) begin
        if (rst) begin
            mem_pend <= 1'b0;
        end else if (bus.req_valid && bus.req_ready) begin
            mem_pend <= 1'b1;
            mem_addr <= bus.addr;
            mem_cnt  <= mem_delay;
        end else if (bus.rsp_valid) begin
            mem_pend <= 1'b0;
        end else if (mem_pend && mem_cnt != 0) begin
            mem_cnt <= mem_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence; cycle cN counts from the first cycle out of reset.
    initial begin
        rst = 1'b1; stallD = 1'b0; flushD = 1'b0; pcsrcE = 1'b0;
        pctargetE = '0; mem_delay = 0;
        tick();
        @(negedge clk);
        chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
        chk("rst_instrD", instrD, NOP);
        chk("rst_pcD", pcD, 32'h0);
        chk("rst_pcplus4D", pcplus4D, 32'h0);
        chk("rst_validD", 32'(validD), 32'd0);
        tick();
        rst = 1'b0;

        // c0 .. c7: free run
        @(negedge clk);
        chk("c0_req_valid", 32'(bus.req_valid), 32'd1);
        chk("c0_addr", bus.addr, 32'h0);
        tick();
        @(negedge clk);
        chk("c1_validD", 32'(validD), 32'd0);
        tick();
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            chk("run_instrD", instrD, KEY ^ (32'(k - 2) * 4));
            chk("run_pcD", pcD, 32'(k - 2) * 4);
            chk("run_pcplus4D", pcplus4D, 32'(k - 1) * 4);
            chk("run_validD", 32'(validD), 32'd1);
            tick();
        end

        // c8 .. c14: stall for three cycles while response for 0x1C arrives
        stallD = 1'b1;
        @(negedge clk);
        chk("c8_req_valid", 32'(bus.req_valid), 32'd0);
        chk("c8_pcD", pcD, 32'h18);
        tick();
        @(negedge clk);
        chk("c9_req_valid", 32'(bus.req_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("c10_instrD_hold", instrD, 32'hA5A5_0018);
        tick();
        stallD = 1'b0;
        @(negedge clk);
        chk("c11_req_valid_bufv", 32'(bus.req_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("c12_instrD_buf", instrD, 32'hA5A5_001C);
        chk("c12_pcD_buf", pcD, 32'h1C);
        chk("c12_addr", bus.addr, 32'h20);
        tick();
        tick();
        mem_delay = 3;
        @(negedge clk);
        chk("c14_pcD", pcD, 32'h20);
        tick();

        // c15 .. c21: redirect to 0x100 while the response for 0x28 is late
        tick();
        pcsrcE = 1'b1; pctargetE = 32'h100;
        @(negedge clk);
        chk("c16_req_valid_redir", 32'(bus.req_valid), 32'd0);
        tick();
        pcsrcE = 1'b0;
        @(negedge clk);
        chk("c17_validD", 32'(validD), 32'd0);
        chk("c17_req_valid_drop", 32'(bus.req_valid), 32'd0);
        tick();
        mem_delay = 0;
        @(negedge clk);
        chk("c18_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("c18_req_valid", 32'(bus.req_valid), 32'd0);
        chk("c18_validD", 32'(validD), 32'd0);
        tick();
        @(negedge clk);
        chk("c19_req_valid", 32'(bus.req_valid), 32'd1);
        chk("c19_addr", bus.addr, 32'h100);
        tick();
        tick();

        // c21 .. c22: redirect to 0x200 coinciding with a response
        pcsrcE = 1'b1; pctargetE = 32'h200;
        @(negedge clk);
        chk("c21_instrD", instrD, 32'hA5A5_0100);
        chk("c21_pcD", pcD, 32'h100);
        chk("c21_req_valid", 32'(bus.req_valid), 32'd0);
        tick();
        pcsrcE = 1'b0;
        @(negedge clk);
        chk("c22_addr", bus.addr, 32'h200);
        chk("c22_req_valid", 32'(bus.req_valid), 32'd1);
        chk("c22_validD", 32'(validD), 32'd0);
        tick();

        // c23 .. c26: flush with a response in the same cycle
        flushD = 1'b1;
        tick();
        flushD = 1'b0;
        @(negedge clk);
        chk("c24_instrD_nop", instrD, NOP);
        chk("c24_validD", 32'(validD), 32'd0);
        chk("c24_req_valid", 32'(bus.req_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("c25_instrD", instrD, 32'hA5A5_0200);
        chk("c25_pcD", pcD, 32'h200);
        chk("c25_validD", 32'(validD), 32'd1);
        tick();
        @(negedge clk);
        chk("c26_pcD", pcD, 32'h204);
        chk("c26_addr", bus.addr, 32'h208);
        tick();

        // c27 .. c31: redirect to the top of the address space and wrap
        pcsrcE = 1'b1; pctargetE = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("c27_req_valid", 32'(bus.req_valid), 32'd0);
        tick();
        pcsrcE = 1'b0;
        @(negedge clk);
        chk("c28_addr", bus.addr, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        chk("c29_addr_wrap", bus.addr, 32'h0);
        tick();
        @(negedge clk);
        chk("c30_instrD", instrD, 32'h5A5A_FFFC);
        chk("c30_pcD", pcD, 32'hFFFF_FFFC);
        chk("c30_pcplus4D", pcplus4D, 32'h0);
        chk("c30_validD", 32'(validD), 32'd1);
        tick();
        @(negedge clk);
        chk("c31_pcD", pcD, 32'h0);
        chk("c31_pcplus4D", pcplus4D, 32'h4);
        tick();

        // Reset in the middle of operation
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req_valid", 32'(bus.req_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("mid_rst_validD", 32'(validD), 32'd0);
        chk("mid_rst_addr", bus.addr, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
